// File: rtl/video_mnist_class_stat_pkg.sv
// Shared constants for the per-frame class statistics stage:
// register map, identification word and FSM state encoding.
package video_mnist_class_stat_pkg;

  localparam logic [31:0] CORE_ID = 32'h5A5A_0C1A;

  localparam int ADR_CORE_ID      = 'h00;
  localparam int ADR_CTL          = 'h01;
  localparam int ADR_STATUS       = 'h02;
  localparam int ADR_FRAME_COUNT  = 'h03;
  localparam int ADR_ERROR_COUNT  = 'h04;
  localparam int ADR_PARAM_TH     = 'h05;
  localparam int ADR_PARAM_HEIGHT = 'h06;
  localparam int ADR_RESULT       = 'h10;
  localparam int ADR_RESULT_TOTAL = 'h1F;

  localparam int HEIGHT_WIDTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Byte-lane merge of a Wishbone write into an existing register value.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_mnist_class_stat_acc.sv
// Bank of CLASS_NUM+1 saturating counters (the last one is the frame total)
// with a result bank that captures the post-increment values on snapshot.
module video_mnist_class_stat_acc #(
  parameter int CLASS_NUM   = 10,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   clear,
  input  logic [CLASS_NUM:0]                     inc,
  input  logic                                   snapshot,
  output logic [CLASS_NUM:0][COUNT_WIDTH-1:0]    result
);

  logic [CLASS_NUM:0][COUNT_WIDTH-1:0] acc_q, acc_d;
  logic [CLASS_NUM:0][COUNT_WIDTH-1:0] res_q, res_d;

  // NOTE: every always_comb output gets a value on every path; a missing
  // branch would infer a latch.
  always_comb begin
    for (int i = 0; i <= CLASS_NUM; i++) begin
      if (clear) begin
        acc_d[i] = COUNT_WIDTH'(inc[i]);
      end else if (inc[i] && (acc_q[i] != '1)) begin
        acc_d[i] = acc_q[i] + 1'b1;
      end else begin
        acc_d[i] = acc_q[i];
      end
    end
    // Snapshot takes acc_d so the frame-end beat itself is included.
    res_d = snapshot ? acc_d : res_q;
  end

  // NOTE: the result bank is a handful of flops, not a RAM, so it is reset
  // to guarantee no stale partial frame is ever readable after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

endmodule

// File: rtl/video_mnist_class_stat.sv
// Class statistics stage: one-beat stream register slice, frame/line FSM,
// per-class counting and a zero-wait-state Wishbone register file.
module video_mnist_class_stat
  import video_mnist_class_stat_pkg::*;
#(
  parameter int TUSER_WIDTH   = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH  = 1,
  parameter int CLASS_NUM     = 10,
  parameter int COUNT_WIDTH   = 20,
  parameter int IMG_Y_NUM     = 480,
  parameter int INIT_PARAM_TH = 1,
  parameter int WB_ADR_WIDTH  = 8,
  parameter int WB_DAT_WIDTH  = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [TUSER_WIDTH-1:0]    s_axi4s_tuser,
  input  logic                      s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0]  s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]   s_axi4s_tcount,
  input  logic                      s_axi4s_tvalid,
  output logic                      s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]    m_axi4s_tuser,
  output logic                      m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0]  m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                      m_axi4s_tvalid,
  input  logic                      m_axi4s_tready,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic                      irq
);

  logic accept;
  logic m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [TUSER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
  logic [TNUMBER_WIDTH-1:0] m_tnumber_q, m_tnumber_d;
  logic [TCOUNT_WIDTH-1:0]  m_tcount_q, m_tcount_d;

  state_e state_q, state_d;
  logic [HEIGHT_WIDTH-1:0] line_q, line_d, height_q, height_d;
  logic [TCOUNT_WIDTH-1:0] th_q, th_d;
  logic ctl_en_q, ctl_en_d, irq_q, irq_d;
  logic [31:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

  logic sof, last_line, counting, clear, snapshot, err_inc, wb_wr;
  logic [CLASS_NUM:0] inc;
  logic [CLASS_NUM:0][COUNT_WIDTH-1:0] result;

  assign s_axi4s_tready = !m_tvalid_q || m_axi4s_tready;
  assign accept         = s_axi4s_tvalid && s_axi4s_tready;
  assign sof            = s_axi4s_tuser[0];
  assign last_line      = (line_q == height_q - 1'b1);

  always_comb begin
    m_tvalid_d  = accept ? 1'b1 : (m_axi4s_tready ? 1'b0 : m_tvalid_q);
    m_tuser_d   = accept ? s_axi4s_tuser   : m_tuser_q;
    m_tlast_d   = accept ? s_axi4s_tlast   : m_tlast_q;
    m_tnumber_d = accept ? s_axi4s_tnumber : m_tnumber_q;
    m_tcount_d  = accept ? s_axi4s_tcount  : m_tcount_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept && sof && !(s_axi4s_tlast && height_q == 1)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (accept && s_axi4s_tlast && last_line) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame-end has priority over a coincident SOF; a restart SOF re-arms line 0.
  always_comb begin
    counting = 1'b0;
    clear    = 1'b0;
    snapshot = 1'b0;
    err_inc  = 1'b0;
    line_d   = line_q;
    unique case (state_q)
      ST_IDLE: if (accept && sof) begin
        counting = 1'b1;
        clear    = 1'b1;
        line_d   = HEIGHT_WIDTH'(s_axi4s_tlast);
        snapshot = s_axi4s_tlast && (height_q == 1);
      end
      ST_ACTIVE: if (accept) begin
        counting = 1'b1;
        if (s_axi4s_tlast && last_line) begin
          snapshot = 1'b1;
        end else if (sof) begin
          clear   = 1'b1;
          err_inc = 1'b1;
          line_d  = HEIGHT_WIDTH'(s_axi4s_tlast);
        end else if (s_axi4s_tlast) begin
          line_d = line_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int n = 0; n < CLASS_NUM; n++) begin
      inc[n] = counting && ctl_en_q && (s_axi4s_tcount >= th_q) &&
               (s_axi4s_tnumber == TNUMBER_WIDTH'(n));
    end
    inc[CLASS_NUM] = counting;
  end

  video_mnist_class_stat_acc #(
    .CLASS_NUM   (CLASS_NUM),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_acc (
    .clk      (aclk),
    .rst_n    (aresetn),
    .clear    (clear),
    .inc      (inc),
    .snapshot (snapshot),
    .result   (result)
  );

  assign wb_wr = s_wb_stb_i && s_wb_we_i;

  always_comb begin
    ctl_en_d    = ctl_en_q;
    th_d        = th_q;
    height_d    = height_q;
    frame_cnt_d = frame_cnt_q + 32'(snapshot);
    err_cnt_d   = err_cnt_q + 32'(err_inc);
    irq_d       = irq_q;
    if (wb_wr && s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL) && s_wb_sel_i[0]) ctl_en_d = s_wb_dat_i[0];
    if (wb_wr && s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH))
      th_d = TCOUNT_WIDTH'(apply_sel(32'(th_q), s_wb_dat_i, s_wb_sel_i));
    if (wb_wr && s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_HEIGHT))
      height_d = HEIGHT_WIDTH'(apply_sel(32'(height_q), s_wb_dat_i, s_wb_sel_i));
    if (wb_wr && s_wb_adr_i == WB_ADR_WIDTH'(ADR_STATUS) && s_wb_sel_i[0] && s_wb_dat_i[1])
      irq_d = 1'b0;
    if (snapshot) irq_d = 1'b1;
  end

  always_comb begin
    s_wb_dat_o = '0;
    case (s_wb_adr_i)
      WB_ADR_WIDTH'(ADR_CORE_ID):      s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      WB_ADR_WIDTH'(ADR_CTL):          s_wb_dat_o = WB_DAT_WIDTH'(ctl_en_q);
      WB_ADR_WIDTH'(ADR_STATUS):       s_wb_dat_o = WB_DAT_WIDTH'({irq_q, state_q == ST_ACTIVE});
      WB_ADR_WIDTH'(ADR_FRAME_COUNT):  s_wb_dat_o = WB_DAT_WIDTH'(frame_cnt_q);
      WB_ADR_WIDTH'(ADR_ERROR_COUNT):  s_wb_dat_o = WB_DAT_WIDTH'(err_cnt_q);
      WB_ADR_WIDTH'(ADR_PARAM_TH):     s_wb_dat_o = WB_DAT_WIDTH'(th_q);
      WB_ADR_WIDTH'(ADR_PARAM_HEIGHT): s_wb_dat_o = WB_DAT_WIDTH'(height_q);
      WB_ADR_WIDTH'(ADR_RESULT_TOTAL): s_wb_dat_o = WB_DAT_WIDTH'(result[CLASS_NUM]);
      default: begin
        for (int n = 0; n < CLASS_NUM; n++) begin
          if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_RESULT + n)) s_wb_dat_o = WB_DAT_WIDTH'(result[n]);
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid_q  <= 1'b0;
      m_tuser_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tnumber_q <= '0;
      m_tcount_q  <= '0;
      state_q     <= ST_IDLE;
      line_q      <= '0;
      ctl_en_q    <= 1'b1;
      th_q        <= TCOUNT_WIDTH'(INIT_PARAM_TH);
      height_q    <= HEIGHT_WIDTH'(IMG_Y_NUM);
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      m_tvalid_q  <= m_tvalid_d;
      m_tuser_q   <= m_tuser_d;
      m_tlast_q   <= m_tlast_d;
      m_tnumber_q <= m_tnumber_d;
      m_tcount_q  <= m_tcount_d;
      state_q     <= state_d;
      line_q      <= line_d;
      ctl_en_q    <= ctl_en_d;
      th_q        <= th_d;
      height_q    <= height_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign m_axi4s_tvalid  = m_tvalid_q;
  assign m_axi4s_tuser   = m_tuser_q;
  assign m_axi4s_tlast   = m_tlast_q;
  assign m_axi4s_tnumber = m_tnumber_q;
  assign m_axi4s_tcount  = m_tcount_q;
  assign s_wb_ack_o      = s_wb_stb_i;
  assign irq             = irq_q;

endmodule

// File: tb/tb_video_mnist_class_stat.sv
// Scoreboard bench for video_mnist_class_stat: drivers push expected stream
// beats and register reads into queues, a negedge monitor pops and compares.
module tb_video_mnist_class_stat;

  localparam int CW = 7;

  typedef struct {
    logic [7:0]  adr;
    logic [31:0] exp;
  } rd_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic [3:0]  s_tnumber = '0;
  logic [0:0]  s_tcount = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [0:0]  m_tuser;
  logic        m_tlast;
  logic [3:0]  m_tnumber;
  logic [0:0]  m_tcount;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [7:0]  wb_adr = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'hF;
  logic        wb_stb = 1'b0;
  logic        wb_ack;
  logic        irq;

  int   vectors = 0;
  int   miscompares = 0;
  bit   rand_bp = 1'b0;
  rd_t        rd_q[$];
  logic [6:0] st_q[$];

  always #5 aclk = ~aclk;

  video_mnist_class_stat #(.COUNT_WIDTH(CW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axi4s_tuser   (s_tuser),
    .s_axi4s_tlast   (s_tlast),
    .s_axi4s_tnumber (s_tnumber),
    .s_axi4s_tcount  (s_tcount),
    .s_axi4s_tvalid  (s_tvalid),
    .s_axi4s_tready  (s_tready),
    .m_axi4s_tuser   (m_tuser),
    .m_axi4s_tlast   (m_tlast),
    .m_axi4s_tnumber (m_tnumber),
    .m_axi4s_tcount  (m_tcount),
    .m_axi4s_tvalid  (m_tvalid),
    .m_axi4s_tready  (m_tready),
    .s_wb_adr_i      (wb_adr),
    .s_wb_dat_i      (wb_dat_i),
    .s_wb_dat_o      (wb_dat_o),
    .s_wb_we_i       (wb_we),
    .s_wb_sel_i      (wb_sel),
    .s_wb_stb_i      (wb_stb),
    .s_wb_ack_o      (wb_ack),
    .irq             (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    m_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compare every output beat and every register read on the negedge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_tvalid && m_tready) begin
        if (st_q.size() == 0) begin
          check("stream_extra_beat", {25'd0, m_tuser, m_tlast, m_tnumber, m_tcount}, 32'hFFFF_FFFF);
        end else begin
          check("stream_beat", {25'd0, m_tuser, m_tlast, m_tnumber, m_tcount}, {25'd0, st_q.pop_front()});
        end
      end
      if (wb_stb) check("wb_ack", 32'(wb_ack), 32'd1);
      if (wb_stb && !wb_we) begin
        if (rd_q.size() == 0) begin
          check("wb_read_unexpected", wb_dat_o, 32'hFFFF_FFFF);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          check($sformatf("read_adr_%02h", r.adr), wb_dat_o, r.exp);
        end
      end
    end
  end

  task automatic wb_rd(input logic [7:0] adr, input logic [31:0] exp);
    rd_t r;
    r.adr = adr;
    r.exp = exp;
    rd_q.push_back(r);
    wb_adr = adr;
    wb_we  = 1'b0;
    wb_stb = 1'b1;
    @(posedge aclk);
    #1;
    wb_stb = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] adr, input logic [31:0] dat);
    wb_adr   = adr;
    wb_dat_i = dat;
    wb_sel   = 4'hF;
    wb_we    = 1'b1;
    wb_stb   = 1'b1;
    @(posedge aclk);
    #1;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic send_beat(input logic sof, input logic last, input logic [3:0] num,
                           input logic cnt, input bit w1c);
    int n;
    s_tuser   = sof;
    s_tlast   = last;
    s_tnumber = num;
    s_tcount  = cnt;
    s_tvalid  = 1'b1;
    if (w1c) begin
      wb_adr = 8'h02; wb_dat_i = 32'h2; wb_sel = 4'hF; wb_we = 1'b1; wb_stb = 1'b1;
    end
    n = 0;
    @(negedge aclk);
    while (!s_tready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (!s_tready) check("stream_stall_timeout", 32'd0, 32'd1);
    else st_q.push_back({sof, last, num, cnt});
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
  endtask

  // mixed: x%4==0 -> tcount 0, x%4==1 -> tnumber 12, others -> num.
  task automatic send_frame(input int w, input int h, input logic [3:0] num,
                            input bit mixed, input bit w1c_last);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        logic [3:0] n;
        logic       c;
        n = num;
        c = 1'b1;
        if (mixed && (x % 4 == 0)) c = 1'b0;
        if (mixed && (x % 4 == 1)) n = 4'd12;
        send_beat(x == 0 && y == 0, x == w - 1, n, c,
                  w1c_last && (x == w - 1) && (y == h - 1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_wb_ack", 32'(wb_ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    wb_rd(8'h00, 32'h5A5A_0C1A);
    wb_rd(8'h01, 32'd1);
    wb_rd(8'h02, 32'd0);
    wb_rd(8'h03, 32'd0);
    wb_rd(8'h04, 32'd0);
    wb_rd(8'h05, 32'd1);
    wb_rd(8'h06, 32'd480);
    wb_rd(8'h13, 32'd0);
    wb_rd(8'h1F, 32'd0);
    wb_rd(8'h07, 32'd0);

    // Uniform 8x4 frame of class 3.
    wb_wr(8'h06, 32'd4);
    send_frame(8, 4, 4'd3, 1'b0, 1'b0);
    check("irq_after_frame1", 32'(irq), 32'd1);
    wb_rd(8'h13, 32'd32);
    wb_rd(8'h1F, 32'd32);
    wb_rd(8'h10, 32'd0);
    wb_rd(8'h03, 32'd1);
    wb_rd(8'h02, 32'd2);
    wb_wr(8'h02, 32'd2);
    check("irq_w1c", 32'(irq), 32'd0);
    wb_rd(8'h02, 32'd0);

    // Mixed frame: low confidence and out-of-range classes only hit TOTAL.
    send_frame(8, 4, 4'd7, 1'b1, 1'b0);
    wb_rd(8'h17, 32'd16);
    wb_rd(8'h1F, 32'd32);
    wb_rd(8'h13, 32'd0);
    wb_rd(8'h03, 32'd2);

    // Short frame: SOF arrives at line 2, then a full frame follows.
    send_frame(8, 2, 4'd5, 1'b0, 1'b0);
    wb_rd(8'h02, 32'd3);
    wb_rd(8'h17, 32'd16);
    wb_rd(8'h04, 32'd0);
    send_frame(8, 4, 4'd5, 1'b0, 1'b0);
    wb_rd(8'h04, 32'd1);
    wb_rd(8'h15, 32'd32);
    wb_rd(8'h17, 32'd0);
    wb_rd(8'h1F, 32'd32);
    wb_rd(8'h03, 32'd3);

    // Random downstream backpressure.
    rand_bp = 1'b1;
    send_frame(8, 4, 4'd9, 1'b0, 1'b0);
    rand_bp = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    wb_rd(8'h19, 32'd32);
    wb_rd(8'h1F, 32'd32);
    wb_rd(8'h03, 32'd4);

    // W1C coinciding with frame end: the set wins.
    wb_wr(8'h02, 32'd2);
    check("irq_cleared_before_race", 32'(irq), 32'd0);
    send_frame(8, 4, 4'd2, 1'b0, 1'b1);
    check("irq_set_wins", 32'(irq), 32'd1);
    wb_rd(8'h02, 32'd2);
    wb_rd(8'h12, 32'd32);
    wb_rd(8'h03, 32'd5);
    wb_wr(8'h02, 32'd2);
    check("irq_w1c_after_race", 32'(irq), 32'd0);

    // 16x10 frame: 160 pixels saturate the 7-bit counters at 127.
    wb_wr(8'h06, 32'd10);
    send_frame(16, 10, 4'd4, 1'b0, 1'b0);
    wb_rd(8'h14, 32'd127);
    wb_rd(8'h1F, 32'd127);
    wb_rd(8'h03, 32'd6);

    // Counting disabled: per-class results zero, total and frame count advance.
    wb_wr(8'h06, 32'd4);
    wb_wr(8'h01, 32'd0);
    wb_rd(8'h01, 32'd0);
    send_frame(8, 4, 4'd6, 1'b0, 1'b0);
    wb_rd(8'h16, 32'd0);
    wb_rd(8'h1F, 32'd32);
    wb_rd(8'h03, 32'd7);

    // Reset pulse mid-frame.
    send_frame(8, 2, 4'd1, 1'b0, 1'b0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    st_q.delete();
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    wb_rd(8'h01, 32'd1);
    wb_rd(8'h02, 32'd0);
    wb_rd(8'h03, 32'd0);
    wb_rd(8'h04, 32'd0);
    wb_rd(8'h05, 32'd1);
    wb_rd(8'h06, 32'd480);
    wb_rd(8'h12, 32'd0);
    wb_rd(8'h1F, 32'd0);

    repeat (4) @(posedge aclk);
    #1;
    check("read_queue_drained", 32'(rd_q.size()), 32'd0);
    check("stream_queue_drained", 32'(st_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
